// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule types, constants and the GF(2^8) doubling helper.
package aes_pkg;

    localparam int unsigned AES_NK     = 8;
    localparam int unsigned AES_NR     = 14;
    localparam int unsigned AES_NWORDS = 60;

    typedef logic [31:0]      aes_word_t;
    typedef logic [3:0][31:0] aes_rkey_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } keyexp_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mod_key_sbox.sv
// Purely combinational AES forward S-box used by the key schedule's SubWord.
module mod_key_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] s;

    always_comb begin
        s = 8'h00;
        case (in_i)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end

    assign out_o = s;

endmodule

// File: rtl/aes256_key_expander.sv
// AES-256 key expander: one schedule word per clock into a 60-word flop array.
// Define KEYEXP_OUT_REG_EN to register key_out (1-cycle read latency).
module aes256_key_expander
    import aes_pkg::*;
#(
    parameter int unsigned NK     = AES_NK,
    parameter int unsigned NR     = AES_NR,
    parameter int unsigned NWORDS = AES_NWORDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         keys_valid,
    input  logic [3:0]   keyAddr,
    output logic [127:0] key_out
);

    keyexp_state_e state_q, state_d;
    aes_word_t     w_q [NWORDS];
    aes_word_t     w_d [NWORDS];
    logic [5:0]    i_q, i_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          keys_valid_q, keys_valid_d;

    aes_word_t prev_word, old_word, sub_in, sub_out, new_word;
    aes_rkey_t rd_key;

    assign prev_word = w_q[i_q - 6'd1];
    assign old_word  = w_q[i_q - 6'd8];
    // RotWord moves byte 0 (LSB) up to byte 3.
    assign sub_in    = (i_q[2:0] == 3'd0) ? {prev_word[7:0], prev_word[31:8]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        mod_key_sbox u_sbox (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        case (i_q[2:0])
            3'd0:    new_word = old_word ^ sub_out ^ {24'h0, rcon_q};
            3'd4:    new_word = old_word ^ sub_out;
            default: new_word = old_word ^ prev_word;
        endcase
    end

    assign key_ready = (state_q != EXPAND);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        rcon_d  = rcon_q;
        w_d     = w_q;
        case (state_q)
            EXPAND: begin
                w_d[i_q] = new_word;
                i_d      = i_q + 6'd1;
                if (i_q[2:0] == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == 6'(NWORDS - 1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                if (key_valid) begin
                    for (int k = 0; k < NK; k++) begin
                        w_d[k] = key_in[32*k +: 32];
                    end
                    i_d     = 6'(NK);
                    rcon_d  = 8'h01;
                    state_d = EXPAND;
                end
            end
        endcase
        // Valid one cycle after entering DONE; drops as soon as a re-key is accepted.
        keys_valid_d = (state_q == DONE) && !key_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            i_q          <= '0;
            rcon_q       <= '0;
            keys_valid_q <= 1'b0;
            for (int k = 0; k < NWORDS; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            rcon_q       <= rcon_d;
            keys_valid_q <= keys_valid_d;
            w_q          <= w_d;
        end
    end

    assign keys_valid = keys_valid_q;

    always_comb begin
        rd_key = '0;
        if (keyAddr <= 4'(NR)) begin
            for (int j = 0; j < 4; j++) begin
                rd_key[j] = w_q[{keyAddr, 2'(j)}];
            end
        end
    end

`ifdef KEYEXP_OUT_REG_EN
    logic [127:0] key_out_q, key_out_d;

    assign key_out_d = rd_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_out_q <= '0;
        end else begin
            key_out_q <= key_out_d;
        end
    end

    assign key_out = key_out_q;
`else
    assign key_out = rd_key;
`endif

endmodule

// File: tb/tb_aes256_key_expander.sv
// Directed self-checking bench for aes256_key_expander using FIPS-197 C.3 / A.3 vectors.
module tb_aes256_key_expander;

    logic         clk;
    logic         reset;
    logic [255:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         keys_valid;
    logic [3:0]   keyAddr;
    logic [127:0] key_out;

    int checks;
    int errors;

    aes256_key_expander dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .keyAddr    (keyAddr),
        .key_out    (key_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS text lists byte 0 first (MSB); the DUT puts byte 0 at the LSB.
    function automatic logic [255:0] rev256(input logic [255:0] x);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) r[8*b +: 8] = x[8*(31-b) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rev128(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = x[8*(15-b) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    localparam logic [255:0] C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] A3_KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] C3_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C3_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [31:0]  A3_W8   = 32'h9ba35411;
    localparam logic [31:0]  A3_W59  = 32'h706c631e;

    // Called at posedge+1; the accepting edge is the one inside.
    task automatic start_key(input logic [255:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_valid(inout int n);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (keys_valid) return;
        end
        n = -1;
    endtask

    task automatic read_key(input logic [3:0] a, output logic [127:0] v);
        keyAddr = a;
`ifdef KEYEXP_OUT_REG_EN
        @(posedge clk);
`endif
        #1;
        v = key_out;
    endtask

    task automatic test_reset();
        logic [127:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_key_ready: got %b want 1", key_ready);
        end
        checks++;
        if (keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_keys_valid: got %b want 0", keys_valid);
        end
        read_key(4'd0, v);
        checks++;
        if (v !== 128'h0) begin
            errors++;
            $display("FAIL reset_key_out: got %h want 0", v);
        end
    endtask

    task automatic test_fips_c3();
        int n;
        logic [127:0] v;
        start_key(rev256(C3_KEY));
        n = 0;
        wait_valid(n);
        checks++;
        if (n !== 53) begin
            errors++;
            $display("FAIL c3_latency: got %0d want 53", n);
        end
        read_key(4'd0, v);
        checks++;
        if (v !== rev128(C3_RK0)) begin
            errors++;
            $display("FAIL c3_rk0: got %h want %h", v, rev128(C3_RK0));
        end
        read_key(4'd1, v);
        checks++;
        if (v !== rev128(C3_RK1)) begin
            errors++;
            $display("FAIL c3_rk1: got %h want %h", v, rev128(C3_RK1));
        end
        read_key(4'd14, v);
        checks++;
        if (v !== rev128(C3_RK14)) begin
            errors++;
            $display("FAIL c3_rk14: got %h want %h", v, rev128(C3_RK14));
        end
    endtask

    task automatic test_addr15();
        logic [127:0] v;
        read_key(4'd15, v);
        checks++;
        if (v !== 128'h0) begin
            errors++;
            $display("FAIL addr15: got %h want 0", v);
        end
        read_key(4'd0, v);
        keyAddr = 4'd14;
        #1;
`ifdef KEYEXP_OUT_REG_EN
        checks++;
        if (key_out !== rev128(C3_RK0)) begin
            errors++;
            $display("FAIL addr_latency_hold: got %h want %h", key_out, rev128(C3_RK0));
        end
        @(posedge clk);
        #1;
`endif
        checks++;
        if (key_out !== rev128(C3_RK14)) begin
            errors++;
            $display("FAIL addr_change: got %h want %h", key_out, rev128(C3_RK14));
        end
    endtask

    task automatic test_rekey();
        int n;
        logic [127:0] v;
        start_key(rev256(A3_KEY));
        checks++;
        if (keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL rekey_drop: got %b want 0", keys_valid);
        end
        n = 0;
        wait_valid(n);
        checks++;
        if (n !== 53) begin
            errors++;
            $display("FAIL rekey_latency: got %0d want 53", n);
        end
        read_key(4'd0, v);
        checks++;
        if (v !== rev128(A3_KEY[255:128])) begin
            errors++;
            $display("FAIL a3_rk0: got %h want %h", v, rev128(A3_KEY[255:128]));
        end
        read_key(4'd2, v);
        checks++;
        if (v[31:0] !== rev32(A3_W8)) begin
            errors++;
            $display("FAIL a3_w8: got %h want %h", v[31:0], rev32(A3_W8));
        end
        read_key(4'd14, v);
        checks++;
        if (v[127:96] !== rev32(A3_W59)) begin
            errors++;
            $display("FAIL a3_w59: got %h want %h", v[127:96], rev32(A3_W59));
        end
    endtask

    task automatic test_ignore_mid_expand();
        int n;
        logic [127:0] v;
        start_key(rev256(C3_KEY));
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            n++;
        end
        start_key(rev256(A3_KEY));
        n++;
        wait_valid(n);
        checks++;
        if (n !== 53) begin
            errors++;
            $display("FAIL ignore_latency: got %0d want 53", n);
        end
        read_key(4'd0, v);
        checks++;
        if (v !== rev128(C3_RK0)) begin
            errors++;
            $display("FAIL ignore_rk0: got %h want %h", v, rev128(C3_RK0));
        end
        read_key(4'd14, v);
        checks++;
        if (v !== rev128(C3_RK14)) begin
            errors++;
            $display("FAIL ignore_rk14: got %h want %h", v, rev128(C3_RK14));
        end
    endtask

    task automatic test_reset_mid_expand();
        logic [127:0] v;
        start_key(rev256(A3_KEY));
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_key_ready: got %b want 1", key_ready);
        end
        checks++;
        if (keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_keys_valid: got %b want 0", keys_valid);
        end
        for (int a = 0; a < 16; a++) begin
            read_key(4'(a), v);
            checks++;
            if (v !== 128'h0) begin
                errors++;
                $display("FAIL abort_key_out[%0d]: got %h want 0", a, v);
            end
        end
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (keys_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_completion: got %b want 0", keys_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        keyAddr   = 4'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_fips_c3();
        test_addr15();
        test_rekey();
        test_ignore_mid_expand();
        test_reset_mid_expand();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
